bram_test_sequencer: RTL
========================

# bram_test_sequencer

Sequences repeated runs of the BRAM tester (`bram_test`). The MicroBlaze GPIO/AXIS side supplies a single configuration beat. The block then issues seed and address-limit beats to the tester, acknowledges each done status, and tallies pass/fail results. It advances the seed between iterations, guards each run with a watchdog, and returns one summary beat to software when the batch ends.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd50_000_000: maximum clocks allowed in WAIT_DONE per iteration.

Ports:
- `clk`  in  1  system clock; all logic in this single domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_tvalid`  in  1  configuration beat valid.
- `cfg_tready`  out  1  high exactly when state is IDLE.
- `cfg_seed`  in  32  initial seed.
- `cfg_addr_max`  in  32  word forwarded unchanged to the tester: {loops, bank-1 enable, address max}.
- `cfg_iters`  in  16  number of iterations; 0 means no run.
- `abort`  in  1  single-cycle request to stop early.
- `seed_tvalid`  out  1  seed beat valid.
- `seed_tready`  in  1  tester ready for seed.
- `seed_tdata`  out  32  current seed.
- `addr_max_tvalid`  out  1  address-limit beat valid.
- `addr_max_tready`  in  1  tester ready for address limit.
- `addr_max_tdata`  out  32  registered `cfg_addr_max`.
- `status_tvalid`  in  1  tester status valid.
- `status_tready`  out  1  done acknowledge to tester.
- `status_tdata`  in  32  tester status: [1] done, [0] pass.
- `result_tvalid`  out  1  summary valid.
- `result_tready`  in  1  summary accepted by software.
- `result_tdata`  out  32  {fail_count[15:0], pass_count[15:0]}.
- `busy`  out  1  high when state is not IDLE.
- `timeout`  out  1  sticky; a watchdog expiry occurred in this batch.
- `aborted`  out  1  sticky; the batch ended because of `abort`.
- `first_fail`  out  16  zero-based index of the first failing iteration; 16'hFFFF if none.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, REPORT.
- IDLE:
  - On `cfg_tvalid`, register seed, addr_max and iters.
  - Clear both counts, `timeout` and `aborted`; set `first_fail` to 16'hFFFF; clear the iteration index.
  - Go to REPORT if `cfg_iters` is 0, otherwise to ISSUE.
- ISSUE:
  - `seed_tvalid` and `addr_max_tvalid` are driven high together.
  - Transfer occurs only in a cycle with `seed_tready` && `addr_max_tready`; both valids then drop and the state goes to WAIT_DONE.
  - Data stays stable while valid is high.
  - If an abort is pending before the transfer, go to REPORT without issuing and set `aborted`.
- WAIT_DONE:
  - The watchdog counts from 0.
  - `status_tready` = (state==WAIT_DONE) && `status_tvalid` && `status_tdata[1]`, combinational and high for exactly one cycle.
  - In that cycle, sample `status_tdata[0]`:
    - pass: `pass_count` += 1.
    - fail: `fail_count` += 1, and `first_fail` takes the iteration index if it is still 16'hFFFF.
  - Also in that cycle: iteration index += 1, remaining -= 1, and the seed steps one LFSR position: seed <= {seed[30:0], seed[31]^seed[21]^seed[1]^seed[0]}.
  - Next state is REPORT if remaining reaches 0 or an abort is pending (then set `aborted`); otherwise ISSUE.
- Watchdog: if the counter reaches `TIMEOUT_CYCLES`-1 without a done:
  - set `timeout` and `fail_count` += 1 (plus `first_fail` if still unset);
  - go to REPORT with no acknowledge and no further iterations.
- Abort:
  - `abort` sets a sticky abort_pending in any non-IDLE state.
  - In WAIT_DONE the block still waits for done (or watchdog) so the tester stays in sync.
  - abort_pending is ignored in IDLE and cleared on entering IDLE.
- REPORT: `result_tvalid` is held high until `result_tready`, then go to IDLE.
  - The counts and flags shown on `result_tdata`, `timeout`, `aborted` and `first_fail` hold until the next cfg accept.
- Widths:
  - Counts are 16-bit and cannot overflow, since pass+fail ≤ `cfg_iters`.
  - The watchdog counter is 32-bit.

## Timing
- Reset (async assert, release synchronized to `clk` by the integration wrapper):
  - state IDLE;
  - all valids, `status_tready`, `busy`, `timeout` and `aborted` are 0;
  - `seed_tdata`, `addr_max_tdata`, `result_tdata` and the counts are 0;
  - `first_fail` is 16'hFFFF;
  - `cfg_tready` is 1.
- Reset mid-run: immediate return to the reset values. The tester shares reset and restarts with it.
- Latency:
  - cfg accept to `seed_tvalid`: 1 cycle.
  - done acknowledge to the next ISSUE: 1 cycle.
  - Final acknowledge to `result_tvalid`: 1 cycle.
- A done that arrives in the same cycle as an `abort` pulse counts the iteration and then goes to REPORT with `aborted`=1.
- A done in the cycle where the watchdog expires is taken as a done; the timeout is not flagged.

## Test plan
- Single pass: cfg seed 0x00000001, addr_max 0x00001FFF, iters 1; model tester reports pass -> one seed beat of 0x00000001, `result_tdata` 0x00000001, `first_fail` 0xFFFF, `busy` low after accept.
- Three iterations: seed 0x1, iters 3, model fails iteration 1 -> seed beats 0x1, 0x3, 0x6; result 0x00010002; `first_fail` 1; exactly three one-cycle `status_tready` pulses.
- Watchdog: `TIMEOUT_CYCLES`=100, tester never reports done -> `timeout`=1 exactly 100 cycles after the transfer, result 0x00010000, `first_fail` 0, no `status_tready`.
- Back-pressure: `seed_tready` low for 20 cycles while `addr_max_tready` is high -> both valids held with stable data, no transfer until both readies are high, and transfer in that cycle.
- Abort: iters 5, `abort` pulsed during WAIT_DONE of iteration 0, tester passes -> result 0x00000001, `aborted`=1, only one seed beat issued.
- Edge/reset: iters 0 -> `result_tvalid` 1 cycle after accept, data 0. Then a new run with `resetn` asserted in WAIT_DONE -> all outputs at reset values asynchronously, `cfg_tready`=1.

Source files
------------

// File: rtl/bram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_test_sequencer
//  Description : Runs a batch of BRAM tester iterations. It takes one
//                configuration beat from software, issues a seed and
//                address-limit beat to the tester for each iteration, and
//                acknowledges each done status. It counts passes and fails,
//                steps the seed through an LFSR between iterations and guards
//                each iteration with a watchdog. At the end of the batch it
//                returns one summary beat to software.
//  Ports       :
//    clk, resetn                      clock, async active-low reset
//    cfg_*                            configuration beat from software
//    abort                            single-cycle early-stop request
//    seed_*, addr_max_*               per-iteration beats to the tester
//    status_*                         done/pass status from the tester
//    result_*                         summary beat {fail[15:0], pass[15:0]}
//    busy, timeout, aborted,
//    first_fail                       batch status flags
//  Revision    : 1.0  initial release
// ============================================================================
module bram_test_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    // configuration from software
    input  logic        cfg_tvalid,
    output logic        cfg_tready,
    input  logic [31:0] cfg_seed,
    input  logic [31:0] cfg_addr_max,
    input  logic [15:0] cfg_iters,
    input  logic        abort,
    // beats to the tester
    output logic        seed_tvalid,
    input  logic        seed_tready,
    output logic [31:0] seed_tdata,
    output logic        addr_max_tvalid,
    input  logic        addr_max_tready,
    output logic [31:0] addr_max_tdata,
    // status from the tester
    input  logic        status_tvalid,
    output logic        status_tready,
    input  logic [31:0] status_tdata,
    // summary to software
    output logic        result_tvalid,
    input  logic        result_tready,
    output logic [31:0] result_tdata,
    // status
    output logic        busy,
    output logic        timeout,
    output logic        aborted,
    output logic [15:0] first_fail
);

    localparam logic [31:0] WD_LAST   = TIMEOUT_CYCLES - 32'd1;
    localparam logic [15:0] FF_UNSET  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_REPORT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] addr_max_q, addr_max_d;
    logic [31:0] wd_q, wd_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] iter_idx_q, iter_idx_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;
    logic [15:0] first_fail_q, first_fail_d;
    logic        timeout_q, timeout_d;
    logic        aborted_q, aborted_d;
    logic        abort_pend_q, abort_pend_d;

    logic        issue_valid;
    logic        issue_xfer;
    logic        done_ack;
    logic        abort_any;
    logic [31:0] seed_next;
    logic        status_unused;

    // Only the done and pass bits of the tester status are meaningful here.
    assign status_unused = ^status_tdata[31:2];

    // A pending abort withdraws the beat so nothing is issued.
    assign issue_valid = (state_q == S_ISSUE) && !abort_pend_q;
    assign issue_xfer  = issue_valid && seed_tready && addr_max_tready;
    assign done_ack    = (state_q == S_WAIT_DONE) && status_tvalid && status_tdata[1];
    // An abort arriving in the done cycle still ends the batch after counting.
    assign abort_any   = abort_pend_q || abort;
    assign seed_next   = {seed_q[30:0], seed_q[31] ^ seed_q[21] ^ seed_q[1] ^ seed_q[0]};

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        addr_max_d   = addr_max_q;
        wd_d         = wd_q;
        remaining_d  = remaining_q;
        iter_idx_d   = iter_idx_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        first_fail_d = first_fail_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;
        abort_pend_d = (state_q != S_IDLE) && abort_any;

        case (state_q)
            S_IDLE: begin
                if (cfg_tvalid) begin
                    seed_d       = cfg_seed;
                    addr_max_d   = cfg_addr_max;
                    remaining_d  = cfg_iters;
                    iter_idx_d   = 16'd0;
                    pass_d       = 16'd0;
                    fail_d       = 16'd0;
                    first_fail_d = FF_UNSET;
                    timeout_d    = 1'b0;
                    aborted_d    = 1'b0;
                    wd_d         = 32'd0;
                    state_d      = (cfg_iters == 16'd0) ? S_REPORT : S_ISSUE;
                end
            end

            S_ISSUE: begin
                wd_d = 32'd0;
                if (abort_pend_q) begin
                    aborted_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (issue_xfer) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (done_ack) begin
                    if (status_tdata[0]) begin
                        pass_d = pass_q + 16'd1;
                    end else begin
                        fail_d = fail_q + 16'd1;
                        if (first_fail_q == FF_UNSET) begin
                            first_fail_d = iter_idx_q;
                        end
                    end
                    iter_idx_d  = iter_idx_q + 16'd1;
                    remaining_d = remaining_q - 16'd1;
                    seed_d      = seed_next;
                    wd_d        = 32'd0;
                    if ((remaining_q == 16'd1) || abort_any) begin
                        aborted_d = abort_any;
                        state_d   = S_REPORT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (wd_q >= WD_LAST) begin
                    // Watchdog expiry counts as a failure and ends the batch.
                    timeout_d = 1'b1;
                    fail_d    = fail_q + 16'd1;
                    if (first_fail_q == FF_UNSET) begin
                        first_fail_d = iter_idx_q;
                    end
                    state_d = S_REPORT;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end

            S_REPORT: begin
                if (result_tready) begin
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            seed_q       <= 32'd0;
            addr_max_q   <= 32'd0;
            wd_q         <= 32'd0;
            remaining_q  <= 16'd0;
            iter_idx_q   <= 16'd0;
            pass_q       <= 16'd0;
            fail_q       <= 16'd0;
            first_fail_q <= FF_UNSET;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            addr_max_q   <= addr_max_d;
            wd_q         <= wd_d;
            remaining_q  <= remaining_d;
            iter_idx_q   <= iter_idx_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign cfg_tready      = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign seed_tvalid     = issue_valid;
    assign addr_max_tvalid = issue_valid;
    assign seed_tdata      = seed_q;
    assign addr_max_tdata  = addr_max_q;
    assign status_tready   = done_ack;
    assign result_tvalid   = (state_q == S_REPORT);
    assign result_tdata    = {fail_q, pass_q};
    assign timeout         = timeout_q;
    assign aborted         = aborted_q;
    assign first_fail      = first_fail_q;

endmodule
`default_nettype wire
